avr_decode_stage: RTL

- Registered, handshaked AVR instruction decode stage between instruction fetch and execute.
- Accepts 16-bit program words with their PC and assembles two-word instructions (jmp, call, lds, sts).
- Emits one decoded record per instruction: opcode, length and operand fields.
- Extends the combinational first-word opcode classifier with pipelining, back-pressure, flush and a wider opcode set.

---
 rtl/avr_dec_pkg.sv | 34 +++
 rtl/avr_op_classify.sv | 35 +++
 rtl/avr_decode_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/avr_dec_pkg.sv
`default_nettype none
// avr_dec_pkg (rev 1.0): opcode codes, FSM states and the two-word predicate
// shared by the AVR decode stage and its first-word classifier.
package avr_dec_pkg;

  localparam logic [7:0] OP_ERR  = 8'd0;
  localparam logic [7:0] OP_LDI  = 8'd1;
  localparam logic [7:0] OP_JMP  = 8'd2;
  localparam logic [7:0] OP_CALL = 8'd3;
  localparam logic [7:0] OP_OUT  = 8'd4;
  localparam logic [7:0] OP_RET  = 8'd5;
  localparam logic [7:0] OP_CLI  = 8'd6;
  localparam logic [7:0] OP_RJMP = 8'd7;
  localparam logic [7:0] OP_EOR  = 8'd8;
  localparam logic [7:0] OP_SUBI = 8'd9;
  localparam logic [7:0] OP_SBCI = 8'd10;
  localparam logic [7:0] OP_BRNE = 8'd11;
  localparam logic [7:0] OP_NOP  = 8'd12;
  localparam logic [7:0] OP_LDS  = 8'd13;
  localparam logic [7:0] OP_STS  = 8'd14;
  localparam logic [7:0] OP_IN   = 8'd15;
  localparam logic [7:0] OP_MOV  = 8'd16;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_WAIT2 = 1'b1
  } state_e;

  function automatic logic is_two_word(input logic [7:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_LDS) || (op == OP_STS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/avr_op_classify.sv
`default_nettype none
// avr_op_classify (rev 1.0): combinational AVR first-word classifier,
// returns the opcode code and whether a second program word follows.
module avr_op_classify
  import avr_dec_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [7:0]  opcode_o,
  output logic        is_long_o
);

  always_comb begin
    opcode_o = OP_ERR;
    if (word_i[15:12] == 4'b1110)                                 opcode_o = OP_LDI;
    else if (word_i[15:9] == 7'b1001010 && word_i[3:1] == 3'b110) opcode_o = OP_JMP;
    else if (word_i[15:9] == 7'b1001010 && word_i[3:1] == 3'b111) opcode_o = OP_CALL;
    else if (word_i[15:11] == 5'b10111)                           opcode_o = OP_OUT;
    else if (word_i == 16'h9508)                                  opcode_o = OP_RET;
    else if (word_i == 16'h94F8)                                  opcode_o = OP_CLI;
    else if (word_i[15:12] == 4'b1100)                            opcode_o = OP_RJMP;
    else if (word_i[15:10] == 6'b001001)                          opcode_o = OP_EOR;
    else if (word_i[15:12] == 4'b0101)                            opcode_o = OP_SUBI;
    else if (word_i[15:12] == 4'b0100)                            opcode_o = OP_SBCI;
    else if (word_i[15:10] == 6'b111101 && word_i[2:0] == 3'b001) opcode_o = OP_BRNE;
    else if (word_i == 16'h0000)                                  opcode_o = OP_NOP;
    else if (word_i[15:9] == 7'b1001000 && word_i[3:0] == 4'b0000) opcode_o = OP_LDS;
    else if (word_i[15:9] == 7'b1001001 && word_i[3:0] == 4'b0000) opcode_o = OP_STS;
    else if (word_i[15:11] == 5'b10110)                           opcode_o = OP_IN;
    else if (word_i[15:10] == 6'b001011)                          opcode_o = OP_MOV;
  end

  assign is_long_o = is_two_word(opcode_o);

endmodule
`default_nettype wire

// File: rtl/avr_decode_stage.sv
`default_nettype none
// avr_decode_stage (rev 1.0): registered, handshaked AVR decode stage that
// assembles two-word instructions. AVR_DEC_PERF_EN adds perf_instr/perf_err.
module avr_decode_stage
  import avr_dec_pkg::*;
#(
  parameter int PC_W     = 22,
  parameter int OPCODE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_word,
  input  logic [PC_W-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic                out_len,
  output logic [PC_W-1:0]     out_pc,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rr,
  output logic [7:0]          out_imm8,
  output logic [5:0]          out_io,
  output logic [PC_W-1:0]     out_rel,
  output logic [PC_W-1:0]     out_target
`ifdef AVR_DEC_PERF_EN
  ,
  output logic [31:0]         perf_instr,
  output logic [31:0]         perf_err
`endif
);

  state_e                state_q;
  logic [15:0]           hold_word_q;
  logic [PC_W-1:0]       hold_pc_q;
  logic                  valid_q;
  logic [OPCODE_W-1:0]   opcode_q;
  logic                  len_q;
  logic [PC_W-1:0]       pc_q, rel_q, target_q;
  logic [4:0]            rd_q, rr_q;
  logic [7:0]            imm_q;
  logic [5:0]            io_q;

  logic                  accept;
  logic [15:0]           dec_word;
  logic [7:0]            cls_op;
  logic                  cls_long;
  logic [4:0]            rd_d, rr_d;
  logic [7:0]            imm_d;
  logic [5:0]            io_d;
  logic [PC_W-1:0]       rel_d, target_d, pc_d;
  logic                  len_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // In WAIT2 the held first word is re-decoded while in_word carries word two.
  assign dec_word = (state_q == ST_WAIT2) ? hold_word_q : in_word;
  assign len_d    = (state_q == ST_WAIT2);
  assign pc_d     = (state_q == ST_WAIT2) ? hold_pc_q : in_pc;

  avr_op_classify u_classify (
    .word_i    (dec_word),
    .opcode_o  (cls_op),
    .is_long_o (cls_long)
  );

  always_comb begin
    rd_d     = '0;
    rr_d     = '0;
    imm_d    = '0;
    io_d     = '0;
    rel_d    = '0;
    target_d = '0;
    case (cls_op)
      OP_LDI, OP_SUBI, OP_SBCI: begin
        rd_d  = {1'b1, dec_word[7:4]};
        imm_d = {dec_word[11:8], dec_word[3:0]};
      end
      OP_OUT: begin
        rr_d = dec_word[8:4];
        io_d = {dec_word[10:9], dec_word[3:0]};
      end
      OP_IN: begin
        rd_d = dec_word[8:4];
        io_d = {dec_word[10:9], dec_word[3:0]};
      end
      OP_EOR, OP_MOV: begin
        rd_d = dec_word[8:4];
        rr_d = {dec_word[9], dec_word[3:0]};
      end
      OP_RJMP: rel_d = {{(PC_W-12){dec_word[11]}}, dec_word[11:0]};
      OP_BRNE: rel_d = {{(PC_W-7){dec_word[9]}}, dec_word[9:3]};
      OP_JMP, OP_CALL: target_d = PC_W'({dec_word[8:4], dec_word[0], in_word});
      OP_LDS: begin
        rd_d     = dec_word[8:4];
        target_d = PC_W'(in_word);
      end
      OP_STS: begin
        rr_d     = dec_word[8:4];
        target_d = PC_W'(in_word);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FIRST;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      len_q       <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      rr_q        <= '0;
      imm_q       <= '0;
      io_q        <= '0;
      rel_q       <= '0;
      target_q    <= '0;
    end else if (flush) begin
      state_q     <= ST_FIRST;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      valid_q     <= 1'b0;
    end else if (accept && state_q == ST_FIRST && cls_long) begin
      // Accept implies any current record is being drained this cycle.
      hold_word_q <= in_word;
      hold_pc_q   <= in_pc;
      state_q     <= ST_WAIT2;
      valid_q     <= 1'b0;
    end else if (accept) begin
      state_q     <= ST_FIRST;
      valid_q     <= 1'b1;
      opcode_q    <= OPCODE_W'(cls_op);
      len_q       <= len_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      rr_q        <= rr_d;
      imm_q       <= imm_d;
      io_q        <= io_d;
      rel_q       <= rel_d;
      target_q    <= target_d;
    end else if (out_ready) begin
      valid_q     <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign out_opcode = opcode_q;
  assign out_len    = len_q;
  assign out_pc     = pc_q;
  assign out_rd     = rd_q;
  assign out_rr     = rr_q;
  assign out_imm8   = imm_q;
  assign out_io     = io_q;
  assign out_rel    = rel_q;
  assign out_target = target_q;

`ifdef AVR_DEC_PERF_EN
  logic [31:0] perf_instr_q, perf_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_q <= '0;
      perf_err_q   <= '0;
    end else if (valid_q && out_ready) begin
      if (perf_instr_q != 32'hFFFF_FFFF) perf_instr_q <= perf_instr_q + 32'd1;
      if (opcode_q == OPCODE_W'(OP_ERR) && perf_err_q != 32'hFFFF_FFFF)
        perf_err_q <= perf_err_q + 32'd1;
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_err   = perf_err_q;
`endif

endmodule
`default_nettype wire
